mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU; consumes ALU RESULT as the byte address and the RT register value as store data.
- Holds the internal data RAM and executes LW/SW/LB/LBU/SB.
- Passes non-memory results through to writeback.
- Presents one registered writeback packet per accepted instruction; stalls upstream with BUSY while an access is in flight.

Parameters:
- DEPTH, 256, data RAM depth in 32-bit words (power of 2).
- AW, 8, word-index width, log2(DEPTH).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- VALID_IN  input  1  instruction presented this cycle.
- OPCODE  input  6  instruction opcode.
- ADDR  input  32  ALU RESULT (byte address, or pass-through value).
- STORE_DATA  input  32  RT value for stores.
- RD_IN  input  5  destination register.
- BUSY  output  1  stage occupied; upstream holds inputs.
- VALID_OUT  output  1  writeback packet valid, one-cycle pulse.
- WB_DATA  output  32  load data or pass-through value.
- RD_OUT  output  5  destination register.
- WB_EN  output  1  register-file write enable for this packet.
- MISALIGN  output  1  misaligned word access flagged.

Behaviour:
- Reset (async, RST=1): state=IDLE, BUSY=0, VALID_OUT=0, WB_DATA=0, RD_OUT=0, WB_EN=0, MISALIGN=0. RAM contents are not cleared.
- Opcodes:
  - LW=100011, LB=100000, LBU=100100 are loads.
  - SW=101011, SB=101000 are stores.
  - Any other opcode is pass-through.
- Accept: VALID_IN=1 and state=IDLE at a rising edge. VALID_IN while BUSY=1 is ignored, not queued.
- Accept latches OPCODE, ADDR, STORE_DATA and RD_IN into internal registers. Later input changes have no effect.
- FSM states: IDLE, ACCESS, RESPOND. BUSY = (state != IDLE), driven from the state register.
- IDLE transitions:
  - Aligned load or store goes to ACCESS.
  - Pass-through or misaligned word access goes to RESPOND.
  - No accept stays in IDLE.
- ACCESS -> RESPOND:
  - Store: write to RAM on this edge.
  - Load: read the RAM word into the output data register on this edge.
- RESPOND -> IDLE. VALID_OUT=1 for exactly the RESPOND cycle; all other outputs hold their values outside RESPOND.
- Latency from the accept edge to VALID_OUT high:
  - Aligned load/store: 2 cycles.
  - Pass-through or misaligned: 1 cycle.
- Addressing:
  - Word index = ADDR[AW+1:2]. Bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4 bytes.
  - Little-endian: byte lane ADDR[1:0]=0 maps to bits 7:0, and 3 maps to bits 31:24.
- Stores:
  - SW writes the full word.
  - SB writes only the lane selected by ADDR[1:0] with STORE_DATA[7:0]; the other three lanes are unchanged.
  - Stores respond with WB_EN=0, WB_DATA=0, MISALIGN=0.
- Loads:
  - LW returns the word.
  - LB returns the selected byte sign-extended to 32 bits.
  - LBU returns the selected byte zero-extended.
  - Loads respond with WB_EN=1, RD_OUT=latched RD_IN.
- Pass-through: WB_DATA=latched ADDR, WB_EN=1, RD_OUT=latched RD_IN.
- Misalignment:
  - LW or SW with ADDR[1:0] != 0 does not touch the RAM.
  - Responds with MISALIGN=1, WB_EN=0, WB_DATA=0.
  - Byte accesses are never misaligned.
- Reset mid-operation:
  - RST asserted in ACCESS before the edge means the store is not committed.
  - State returns to IDLE and no VALID_OUT is produced for the aborted instruction.
- A load from a word never written returns X in simulation; the bench preloads the RAM or stores first.

Test Plan:
- Reset, then SW ADDR=0x10, STORE_DATA=0xDEADBEEF, RD_IN=3 -> BUSY=1 for 2 cycles; VALID_OUT pulses 2 cycles after accept with WB_EN=0, MISALIGN=0.
- LW ADDR=0x10 after the above store -> WB_DATA=0xDEADBEEF, WB_EN=1, RD_OUT=RD_IN, VALID_OUT 2 cycles after accept.
- SB ADDR=0x11, STORE_DATA=0x000000A5, then:
  - LW ADDR=0x10 -> 0xDEADA5EF.
  - LB ADDR=0x11 -> 0xFFFFFFA5.
  - LBU ADDR=0x11 -> 0x000000A5.
- SW ADDR=0x16 (misaligned) -> VALID_OUT after 1 cycle, MISALIGN=1, WB_EN=0; a following LW ADDR=0x14 shows the word unchanged.
- Opcode 000000 with ADDR=27, RD_IN=9 -> VALID_OUT after 1 cycle, WB_DATA=27, RD_OUT=9, WB_EN=1. A second VALID_IN asserted while BUSY=1 is ignored.
- Wrap and reset checks:
  - SW ADDR=DEPTH*4+0x4 (=0x404), data 0x12345678; LW ADDR=0x4 -> 0x12345678.
  - SW ADDR=0x20, data 1, with RST pulsed during ACCESS -> outputs zero, no VALID_OUT, and a later LW 0x20 does not return 1 (preload 0 first).

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: owns the data RAM, executes LW/SW/LB/LBU/SB and passes
// other results through, emitting one registered writeback packet per instruction.
module mem_access_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    input  logic [5:0]  OPCODE,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD_IN,
    output logic        BUSY,
    output logic        VALID_OUT,
    output logic [31:0] WB_DATA,
    output logic [4:0]  RD_OUT,
    output logic        WB_EN,
    output logic        MISALIGN
);
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t        state_q;
    logic [5:0]    op_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   sdata_q;
    logic [4:0]    rd_q;
    logic          valid_q, wb_en_q, misal_q;
    logic [31:0]   wb_data_q;
    logic [4:0]    rd_out_q;

    logic [31:0]   mem [DEPTH];

    logic          in_mem, in_misal, q_load;
    logic [31:0]   rd_word, ld_data_d;
    logic [7:0]    rd_byte;

    always_comb begin
        in_mem   = (OPCODE inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB});
        in_misal = ((OPCODE == OP_LW) || (OPCODE == OP_SW)) && (ADDR[1:0] != 2'b00);
        q_load   = (op_q inside {OP_LW, OP_LB, OP_LBU});
    end

    // Load path: word fetch, then little-endian lane select and extension.
    always_comb begin
        rd_word = mem[addr_q[AW+1:2]];
        rd_byte = 8'(rd_word >> {addr_q[1:0], 3'b000});
        case (op_q)
            OP_LW:   ld_data_d = rd_word;
            OP_LB:   ld_data_d = {{24{rd_byte[7]}}, rd_byte};
            default: ld_data_d = {24'h0, rd_byte};
        endcase
    end

    // RST is sampled so a reset landing on the ACCESS edge drops the store.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == ACCESS) begin
            if (op_q == OP_SW)
                mem[addr_q[AW+1:2]] <= sdata_q;
            else if (op_q == OP_SB)
                mem[addr_q[AW+1:2]][{addr_q[1:0], 3'b000} +: 8] <= sdata_q[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            wb_data_q <= '0;
            rd_out_q  <= '0;
            wb_en_q   <= 1'b0;
            misal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (VALID_IN) begin
                        op_q    <= OPCODE;
                        addr_q  <= ADDR[AW+1:0];
                        sdata_q <= STORE_DATA;
                        rd_q    <= RD_IN;
                        if (in_mem && !in_misal) begin
                            state_q <= ACCESS;
                        end else begin
                            // Pass-through and misaligned word ops answer without RAM.
                            state_q   <= RESPOND;
                            valid_q   <= 1'b1;
                            rd_out_q  <= RD_IN;
                            wb_data_q <= in_misal ? 32'h0 : ADDR;
                            wb_en_q   <= !in_misal;
                            misal_q   <= in_misal;
                        end
                    end
                end
                ACCESS: begin
                    state_q   <= RESPOND;
                    valid_q   <= 1'b1;
                    rd_out_q  <= rd_q;
                    misal_q   <= 1'b0;
                    wb_en_q   <= q_load;
                    wb_data_q <= q_load ? ld_data_d : 32'h0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = (state_q != IDLE);
    assign VALID_OUT = valid_q;
    assign WB_DATA   = wb_data_q;
    assign RD_OUT    = rd_out_q;
    assign WB_EN     = wb_en_q;
    assign MISALIGN  = misal_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected packets into a
// scoreboard queue, an independent monitor pops and compares on VALID_OUT.
module tb_mem_access_stage;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, PT = 6'b000000;

    logic        CLK = 1'b0, RST = 1'b1, VALID_IN = 1'b0;
    logic [5:0]  OPCODE = '0;
    logic [31:0] ADDR = '0, STORE_DATA = '0;
    logic [4:0]  RD_IN = '0;
    logic        BUSY, VALID_OUT, WB_EN, MISALIGN;
    logic [31:0] WB_DATA;
    logic [4:0]  RD_OUT;

    mem_access_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .OPCODE(OPCODE), .ADDR(ADDR),
        .STORE_DATA(STORE_DATA), .RD_IN(RD_IN), .BUSY(BUSY), .VALID_OUT(VALID_OUT),
        .WB_DATA(WB_DATA), .RD_OUT(RD_OUT), .WB_EN(WB_EN), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        en, mis, chk_rd;
        int          at;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every VALID_OUT must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (VALID_OUT === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid_out", 32'(VALID_OUT), 32'h0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("latency", 32'(cyc), 32'(e.at));
                check("wb_data", WB_DATA, e.d);
                check("wb_en", 32'(WB_EN), 32'(e.en));
                check("misalign", 32'(MISALIGN), 32'(e.mis));
                if (e.chk_rd) check("rd_out", 32'(RD_OUT), 32'(e.rd));
            end
        end
    end

    // Called at a negedge with BUSY low; returns at a negedge with BUSY low.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [31:0] ed, input logic een,
                         input logic emis, input logic chk_rd, input int lat, input bit hold);
        exp_t e;
        int   n;
        e.d = ed; e.rd = rd; e.en = een; e.mis = emis; e.chk_rd = chk_rd; e.at = cyc + lat;
        sbq.push_back(e);
        VALID_IN = 1'b1; OPCODE = op; ADDR = a; STORE_DATA = sd; RD_IN = rd;
        @(posedge CLK);
        @(negedge CLK);
        if (hold) begin
            // Keep requesting a different op while busy; it must be dropped.
            OPCODE = PT; ADDR = 32'd99; RD_IN = 5'd1;
        end else begin
            VALID_IN = 1'b0; OPCODE = 6'h3f; ADDR = 32'hffff_ffff; STORE_DATA = '1; RD_IN = '1;
        end
        n = 0;
        while (BUSY === 1'b1 && n < 10) begin
            n++;
            @(negedge CLK);
        end
        VALID_IN = 1'b0;
        check("busy_cycles", 32'(n), 32'(lat));
    endtask

    task automatic ld(input logic [5:0] op, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] ed);
        issue(op, a, 32'h0, rd, ed, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    endtask

    task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
        issue(op, a, sd, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_valid", 32'(VALID_OUT), 32'h0);
        check("rst_wb_data", WB_DATA, 32'h0);
        check("rst_rd_out", 32'(RD_OUT), 32'h0);
        check("rst_wb_en", 32'(WB_EN), 32'h0);
        check("rst_misalign", 32'(MISALIGN), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        st(SW, 32'h10, 32'hDEADBEEF);
        ld(LW, 32'h10, 5'd4, 32'hDEADBEEF);
        st(SB, 32'h11, 32'h000000A5);
        ld(LW, 32'h10, 5'd5, 32'hDEADA5EF);
        ld(LB, 32'h11, 5'd6, 32'hFFFFFFA5);
        ld(LBU, 32'h11, 5'd7, 32'h000000A5);
        ld(LB, 32'h13, 5'd8, 32'hFFFFFFDE);
        ld(LBU, 32'h10, 5'd10, 32'h000000EF);

        // Misaligned word accesses: single-cycle error response, RAM untouched.
        st(SW, 32'h14, 32'h55667788);
        issue(SW, 32'h16, 32'hFFFFFFFF, 5'd11, 32'h0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        ld(LW, 32'h14, 5'd12, 32'h55667788);
        issue(LW, 32'h12, 32'h0, 5'd13, 32'h0, 1'b0, 1'b1, 1'b1, 1, 1'b0);

        // Pass-through, with a second request held while busy.
        issue(PT, 32'd27, 32'h0, 5'd9, 32'd27, 1'b1, 1'b0, 1'b1, 1, 1'b1);

        // Address wraps modulo DEPTH*4 bytes.
        st(SW, 32'h404, 32'h12345678);
        ld(LW, 32'h4, 5'd14, 32'h12345678);

        // Reset landing during ACCESS aborts the store and its response.
        st(SW, 32'h20, 32'h0);
        VALID_IN = 1'b1; OPCODE = SW; ADDR = 32'h20; STORE_DATA = 32'h1; RD_IN = 5'd15;
        @(posedge CLK);
        @(negedge CLK);
        VALID_IN = 1'b0;
        check("pre_abort_busy", 32'(BUSY), 32'h1);
        RST = 1'b1;
        #1;
        check("abort_busy", 32'(BUSY), 32'h0);
        check("abort_valid", 32'(VALID_OUT), 32'h0);
        check("abort_wb_data", WB_DATA, 32'h0);
        check("abort_wb_en", 32'(WB_EN), 32'h0);
        check("abort_misalign", 32'(MISALIGN), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        ld(LW, 32'h20, 5'd16, 32'h0);

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
